// File: rtl/coherence_bus_ctrl_if.sv
// Controller-side bus for a 2-core coherence controller: cache requests, snoop lines and the RAM port.
// ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
interface coherence_bus_ctrl_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       iREN, dREN, dWEN;
  logic [CPUS-1:0][31:0] iaddr, daddr, dstore;
  logic [CPUS-1:0]       cctrans, ccwrite;
  logic [31:0]           ramload;
  logic [1:0]            ramstate;
  logic [CPUS-1:0]       iwait, dwait;
  logic [CPUS-1:0][31:0] iload, dload;
  logic [CPUS-1:0]       ccwait, ccinv;
  logic [CPUS-1:0][31:0] ccsnoopaddr;
  logic [31:0]           ramaddr, ramstore;
  logic                  ramREN, ramWEN;

  modport master (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr, ramaddr, ramstore,
           ramREN, ramWEN
  );

  modport slave (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr, ramaddr, ramstore,
           ramREN, ramWEN
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// 2-core MSI memory/coherence controller: arbitrates I/D traffic onto one RAM port and runs snoops.
// Optional BUS_STATS_EN adds saturating counters stat_c2c / stat_inv / stat_ram.
module coherence_bus_ctrl #(
  parameter int CPUS          = 2,
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  coherence_bus_ctrl_if.master ccif
`ifdef BUS_STATS_EN
  ,
  output logic [31:0]          stat_c2c,
  output logic [31:0]          stat_inv,
  output logic [31:0]          stat_ram
`endif
);
  localparam int CW = $clog2(SNOOP_TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [2:0] {IDLE, IFETCH, DWB, DRD, SNOOP, C2C, INV} state_t;

  if (CPUS != 2) begin : g_cpus_check
    $error("coherence_bus_ctrl supports CPUS == 2 only");
  end

  state_t        r_state, w_next;
  logic          r_req, r_rr, r_excl;
  logic [CW-1:0] r_cnt;
  logic          w_pick, w_done, w_oth, w_ram_ok;
  ramstate_t     w_rs;

  assign w_rs     = ramstate_t'(ccif.ramstate);
  assign w_ram_ok = (w_rs == ACCESS) || (w_rs == ERROR);
  assign w_oth    = ~r_req;

  always_comb begin
    w_next           = r_state;
    w_pick           = r_rr;
    w_done           = 1'b0;
    ccif.iwait       = '1;
    ccif.dwait       = '1;
    ccif.iload       = '0;
    ccif.dload       = '0;
    ccif.ccwait      = '0;
    ccif.ccinv       = '0;
    ccif.ccsnoopaddr = '0;
    ccif.ramaddr     = '0;
    ccif.ramstore    = '0;
    ccif.ramREN      = 1'b0;
    ccif.ramWEN      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|ccif.dWEN) begin
          w_pick = ccif.dWEN[r_rr] ? r_rr : ~r_rr;
          w_next = DWB;
        end else if (|ccif.dREN) begin
          w_pick = ccif.dREN[r_rr] ? r_rr : ~r_rr;
          w_next = ccif.cctrans[w_pick] ? SNOOP : INV;
        end else if (|ccif.iREN) begin
          w_pick = ccif.iREN[r_rr] ? r_rr : ~r_rr;
          w_next = IFETCH;
        end
      end
      IFETCH: begin
        ccif.ramREN  = 1'b1;
        ccif.ramaddr = ccif.iaddr[r_req];
        if (w_ram_ok) begin
          ccif.iwait[r_req] = 1'b0;
          ccif.iload[r_req] = ccif.ramload;
          w_next            = IDLE;
        end
      end
      DWB: begin
        ccif.ramWEN   = 1'b1;
        ccif.ramaddr  = ccif.daddr[r_req];
        ccif.ramstore = ccif.dstore[r_req];
        if (w_ram_ok) begin
          ccif.dwait[r_req] = 1'b0;
          w_done            = 1'b1;
          w_next            = IDLE;
        end
      end
      SNOOP: begin
        ccif.ccwait[w_oth]      = 1'b1;
        ccif.ccinv[w_oth]       = r_excl;
        ccif.ccsnoopaddr[w_oth] = ccif.daddr[r_req];
        if (ccif.ccwrite[w_oth]) begin
          w_next = C2C;
        end else if (ccif.cctrans[w_oth] || (r_cnt == CW'(SNOOP_TIMEOUT - 1))) begin
          w_next = DRD;
        end
      end
      C2C: begin
        // Snoopee stays stalled while its M data is forwarded and written back.
        ccif.ccwait[w_oth]      = 1'b1;
        ccif.ccinv[w_oth]       = r_excl;
        ccif.ccsnoopaddr[w_oth] = ccif.daddr[r_req];
        ccif.dload[r_req]       = ccif.dstore[w_oth];
        ccif.ramWEN             = 1'b1;
        ccif.ramaddr            = ccif.daddr[r_req];
        ccif.ramstore           = ccif.dstore[w_oth];
        if (w_ram_ok) begin
          ccif.dwait[r_req] = 1'b0;
          ccif.dwait[w_oth] = 1'b0;
          w_done            = 1'b1;
          w_next            = IDLE;
        end
      end
      DRD: begin
        ccif.ramREN  = 1'b1;
        ccif.ramaddr = ccif.daddr[r_req];
        if (w_ram_ok) begin
          ccif.dwait[r_req] = 1'b0;
          ccif.dload[r_req] = ccif.ramload;
          w_done            = 1'b1;
          w_next            = IDLE;
        end
      end
      INV: begin
        if (r_cnt < CW'(2)) begin
          ccif.ccinv[w_oth]  = 1'b1;
          ccif.ccwait[w_oth] = 1'b1;
        end else begin
          ccif.dwait[r_req] = 1'b0;
          w_done            = 1'b1;
          w_next            = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_rr    <= 1'b0;
      r_excl  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + CW'(1);
      if ((r_state == IDLE) && (w_next != IDLE)) begin
        r_req  <= w_pick;
        r_excl <= ccif.ccwrite[w_pick];
      end
      if (w_done) r_rr <= ~r_rr;
    end
  end

`ifdef BUS_STATS_EN
  logic [31:0] r_stat_c2c, r_stat_inv, r_stat_ram;
  logic        w_inv_ev;

  assign w_inv_ev = ((r_state != INV) && (w_next == INV)) ||
                    ((r_state == IDLE) && (w_next == SNOOP) && ccif.ccwrite[w_pick]);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_c2c <= '0;
      r_stat_inv <= '0;
      r_stat_ram <= '0;
    end else begin
      if ((r_state != C2C) && (w_next == C2C) && (r_stat_c2c != '1)) r_stat_c2c <= r_stat_c2c + 32'd1;
      if (w_inv_ev && (r_stat_inv != '1)) r_stat_inv <= r_stat_inv + 32'd1;
      if ((ccif.ramREN || ccif.ramWEN) && (r_stat_ram != '1)) r_stat_ram <= r_stat_ram + 32'd1;
    end
  end

  assign stat_c2c = r_stat_c2c;
  assign stat_inv = r_stat_inv;
  assign stat_ram = r_stat_ram;
`else
  // Default build carries no statistics logic.
`endif
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Randomized self-checking bench for coherence_bus_ctrl; the bench plays both caches and the RAM.
module tb_coherence_bus_ctrl;
  localparam int         TO     = 16;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  coherence_bus_ctrl_if #(.CPUS(2)) bus ();

`ifdef BUS_STATS_EN
  logic [31:0] stat_c2c, stat_inv, stat_ram;
`endif

  coherence_bus_ctrl #(.CPUS(2), .SNOOP_TIMEOUT(TO)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .ccif (bus)
`ifdef BUS_STATS_EN
    ,
    .stat_c2c (stat_c2c),
    .stat_inv (stat_inv),
    .stat_ram (stat_ram)
`endif
  );

  int          total = 0, bad = 0;
  logic [31:0] ram     [256];
  logic [31:0] exp_mem [256];
  int          rr_m;
  int          busy_left, wr_cnt, rd_cnt, strobe_cnt, cw_cnt, ci_cnt;
  logic [31:0] wr_addr, wr_data, snp_addr;
  int          snp_core, snp_dly, snp_cnt;
  bit          snp_write, snp_chk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: act as RAM and snoopee at the negedge, then sample #1 later.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    bus.ramstate = RS_FREE;
    if (bus.ramREN || bus.ramWEN) begin
      strobe_cnt++;
      if (busy_left > 0) begin
        bus.ramstate = RS_BUSY;
        busy_left--;
      end else begin
        bus.ramstate = ($urandom_range(0, 3) == 0) ? RS_ERR : RS_ACC;
        bus.ramload  = ram[bus.ramaddr[9:2]];
        if (bus.ramWEN) begin
          ram[bus.ramaddr[9:2]] = bus.ramstore;
          wr_cnt++;
          wr_addr = bus.ramaddr;
          wr_data = bus.ramstore;
        end else begin
          rd_cnt++;
        end
      end
    end
    if (snp_dly >= 0 && bus.ccwait[snp_core]) begin
      if (snp_cnt == snp_dly) begin
        bus.ccwrite[snp_core] = snp_write;
        bus.cctrans[snp_core] = !snp_write;
      end
      snp_cnt++;
    end
    #1;
    check_val("ram_strobe_excl", 64'(bus.ramREN & bus.ramWEN), 64'(0));
    if (bus.ccwait[snp_core]) begin
      cw_cnt++;
      if (bus.ccinv[snp_core]) ci_cnt++;
      if (snp_chk) check_val("snoopaddr", 64'(bus.ccsnoopaddr[snp_core]), 64'(snp_addr));
    end
  endtask

  task automatic wait_done(input bit is_i, input int k, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while ((is_i ? bus.iwait[k] : bus.dwait[k]) && n < 200);
    check_val("done_seen", 64'(is_i ? bus.iwait[k] : bus.dwait[k]), 64'(0));
  endtask

  task automatic chk_reset(input string t);
    check_val({t, "_iwait"},  64'(bus.iwait),       64'(2'b11));
    check_val({t, "_dwait"},  64'(bus.dwait),       64'(2'b11));
    check_val({t, "_ccwait"}, 64'(bus.ccwait),      64'(0));
    check_val({t, "_ccinv"},  64'(bus.ccinv),       64'(0));
    check_val({t, "_ramren"}, 64'(bus.ramREN),      64'(0));
    check_val({t, "_ramwen"}, 64'(bus.ramWEN),      64'(0));
    check_val({t, "_ramaddr"},  64'(bus.ramaddr),   64'(0));
    check_val({t, "_ramstore"}, 64'(bus.ramstore),  64'(0));
    check_val({t, "_snpaddr"}, bus.ccsnoopaddr,     64'(0));
    check_val({t, "_iload"},  bus.iload,            64'(0));
    check_val({t, "_dload"},  bus.dload,            64'(0));
  endtask

  task automatic do_fetch(input int c, input bit both, input logic [31:0] a0, input logic [31:0] a1,
                          input int busy);
    int k, n, first;
    logic [31:0] ak;
    bus.iaddr[c] = a0;
    bus.iREN[c]  = 1'b1;
    if (both) begin
      bus.iaddr[1-c] = a1;
      bus.iREN[1-c]  = 1'b1;
    end
    first = both ? rr_m : c;
    for (int s = 0; s < (both ? 2 : 1); s++) begin
      k  = (s == 0) ? first : 1 - first;
      ak = (k == c) ? a0 : a1;
      busy_left = busy; wr_cnt = 0; rd_cnt = 0;
      wait_done(1'b1, k, n);
      check_val("if_latency", 64'(n), 64'(busy + 1));
      check_val("iload", 64'(bus.iload[k]), 64'(exp_mem[ak[9:2]]));
      check_val("if_other_wait", 64'(bus.iwait[1-k]), 64'(1));
      bus.iREN[k] = 1'b0;
      tick();
      check_val("iwait_pulse", 64'(bus.iwait[k]), 64'(1));
      check_val("if_writes", 64'(wr_cnt), 64'(0));
      check_val("if_reads", 64'(rd_cnt), 64'(1));
    end
  endtask

  task automatic do_wb(input int c, input bit both, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [31:0] a1, input logic [31:0] d1, input int busy);
    int k, n, first;
    logic [31:0] ak, dk;
    bus.daddr[c] = a0; bus.dstore[c] = d0; bus.dWEN[c] = 1'b1;
    if (both) begin
      bus.daddr[1-c] = a1; bus.dstore[1-c] = d1; bus.dWEN[1-c] = 1'b1;
    end
    first = both ? rr_m : c;
    for (int s = 0; s < (both ? 2 : 1); s++) begin
      k  = (s == 0) ? first : 1 - first;
      ak = (k == c) ? a0 : a1;
      dk = (k == c) ? d0 : d1;
      busy_left = busy; wr_cnt = 0; rd_cnt = 0;
      wait_done(1'b0, k, n);
      check_val("wb_latency", 64'(n), 64'(busy + 1));
      check_val("wb_writes", 64'(wr_cnt), 64'(1));
      check_val("wb_addr", 64'(wr_addr), 64'(ak));
      check_val("wb_data", 64'(wr_data), 64'(dk));
      exp_mem[ak[9:2]] = dk;
      rr_m = 1 - rr_m;
      bus.dWEN[k] = 1'b0;
      tick();
      check_val("dwait_pulse", 64'(bus.dwait[k]), 64'(1));
    end
  endtask

  // dly < 0: snoopee never answers (timeout); write=1: snoopee answers with M data.
  task automatic do_snoop(input int c, input bit excl, input int dly, input bit write,
                          input logic [31:0] a, input logic [31:0] dj, input int busy);
    int j, n, scyc, cw_exp;
    j = 1 - c;
    bus.daddr[c] = a; bus.dREN[c] = 1'b1; bus.cctrans[c] = 1'b1; bus.ccwrite[c] = excl;
    bus.dstore[j] = dj;
    snp_core = j; snp_dly = dly; snp_write = write; snp_cnt = 0; snp_chk = 1'b1; snp_addr = a;
    cw_cnt = 0; ci_cnt = 0; busy_left = busy; wr_cnt = 0; rd_cnt = 0;
    wait_done(1'b0, c, n);
    scyc = (dly < 0) ? TO : dly + 1;
    check_val("snp_latency", 64'(n), 64'(scyc + 1 + busy));
    if (write) begin
      cw_exp = scyc + 1 + busy;
      check_val("c2c_dload", 64'(bus.dload[c]), 64'(dj));
      check_val("c2c_dwait_snoopee", 64'(bus.dwait[j]), 64'(0));
      check_val("c2c_writes", 64'(wr_cnt), 64'(1));
      check_val("c2c_addr", 64'(wr_addr), 64'(a));
      check_val("c2c_data", 64'(wr_data), 64'(dj));
      check_val("c2c_reads", 64'(rd_cnt), 64'(0));
      exp_mem[a[9:2]] = dj;
    end else begin
      cw_exp = scyc;
      check_val("drd_dload", 64'(bus.dload[c]), 64'(exp_mem[a[9:2]]));
      check_val("drd_ccwait_clear", 64'(bus.ccwait[j]), 64'(0));
      check_val("drd_reads", 64'(rd_cnt), 64'(1));
      check_val("drd_writes", 64'(wr_cnt), 64'(0));
    end
    check_val("snp_ccwait_cycles", 64'(cw_cnt), 64'(cw_exp));
    check_val("snp_ccinv_cycles", 64'(ci_cnt), 64'(excl ? cw_exp : 0));
    rr_m = 1 - rr_m;
    bus.dREN[c] = 1'b0; bus.cctrans[c] = 1'b0; bus.ccwrite[c] = 1'b0;
    bus.cctrans[j] = 1'b0; bus.ccwrite[j] = 1'b0;
    snp_dly = -1; snp_chk = 1'b0;
    tick();
    check_val("snp_dwait_after", 64'(bus.dwait[c]), 64'(1));
    check_val("snp_ccwait_after", 64'(bus.ccwait[j]), 64'(0));
  endtask

  task automatic do_inv(input int c, input logic [31:0] a);
    int j;
    j = 1 - c;
    bus.daddr[c] = a; bus.dREN[c] = 1'b1; bus.cctrans[c] = 1'b0; bus.ccwrite[c] = 1'b0;
    snp_core = j; strobe_cnt = 0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      if (n < 3) begin
        check_val("inv_ccinv", 64'(bus.ccinv[j]), 64'(1));
        check_val("inv_ccwait", 64'(bus.ccwait[j]), 64'(1));
        check_val("inv_dwait_hold", 64'(bus.dwait[c]), 64'(1));
      end else begin
        check_val("inv_dwait_done", 64'(bus.dwait[c]), 64'(0));
        check_val("inv_ccinv_drop", 64'(bus.ccinv[j]), 64'(0));
      end
    end
    check_val("inv_no_ram", 64'(strobe_cnt), 64'(0));
    rr_m = 1 - rr_m;
    bus.dREN[c] = 1'b0;
    tick();
    check_val("inv_dwait_after", 64'(bus.dwait[c]), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, c;
    bit both, excl;
    logic [31:0] a0, a1;
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.cctrans = '0; bus.ccwrite = '0;
    bus.ramload = '0; bus.ramstate = RS_FREE;
    snp_core = 0; snp_dly = -1; snp_chk = 1'b0; rr_m = 0; busy_left = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      exp_mem[i] = ram[i];
    end
    ram[8'h40]     = 32'hDEADBEEF;
    exp_mem[8'h40] = 32'hDEADBEEF;

    nRST = 1'b1;
    #1 nRST = 1'b0;
    repeat (3) tick();
    chk_reset("reset");
    nRST = 1'b1;

    do_fetch(0, 1'b0, 32'h100, 32'h0, 3);
    check_val("tp1_iload_const", 64'(exp_mem[8'h40]), 64'(32'hDEADBEEF));
    do_wb(0, 1'b1, 32'h040, 32'hA5A5_0001, 32'h044, 32'h5A5A_0002, 1);
    do_fetch(1, 1'b1, 32'h040, 32'h044, 0);
    do_snoop(0, 1'b1, 2, 1'b1, 32'h200, 32'h1234, 1);
    do_snoop(1, 1'b0, -1, 1'b0, 32'h300, 32'h0, 2);
    do_inv(0, 32'h080);

    // Reset in the middle of a stalled writeback must abort it cleanly.
    bus.daddr[0] = 32'h3F0; bus.dstore[0] = 32'hBAD0_BAD0; bus.dWEN[0] = 1'b1;
    busy_left = 50; wr_cnt = 0;
    tick(); tick();
    check_val("pre_rst_wen", 64'(bus.ramWEN), 64'(1));
    nRST = 1'b0;
    #1;
    chk_reset("midrst");
    bus.dWEN[0] = 1'b0; busy_left = 0; rr_m = 0;
    tick();
    check_val("midrst_no_write", 64'(wr_cnt), 64'(0));
    nRST = 1'b1;
    do_wb(1, 1'b1, 32'h3F0, 32'h0000_1111, 32'h3F4, 32'h0000_2222, 0);

    repeat (40) begin
      kind = $urandom_range(0, 4);
      c    = $urandom_range(0, 1);
      both = 1'($urandom_range(0, 1));
      excl = 1'($urandom_range(0, 1));
      a0   = 32'($urandom_range(0, 255)) << 2;
      a1   = 32'($urandom_range(0, 255)) << 2;
      case (kind)
        0: do_fetch(c, both, a0, a1, $urandom_range(0, 3));
        1: do_wb(c, both, a0, $urandom, a1, $urandom, $urandom_range(0, 3));
        2: do_snoop(c, excl, ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1)),
                    1'b0, a0, $urandom, $urandom_range(0, 3));
        3: do_snoop(c, excl, int'($urandom_range(0, TO - 1)), 1'b1, a0, $urandom,
                    $urandom_range(0, 3));
        default: do_inv(c, a0);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
Memory/coherence controller that drives the cc side of cache_control_if for a 2-core system. It sits between the per-core icaches/dcaches and the single-ported RAM.
- Arbitrates instruction fetches, data reads and writebacks onto one RAM port.
- Runs snoop transactions: MSI invalidate and cache-to-cache transfer with concurrent RAM writeback.
- One transaction in flight at a time; single-word granularity.

Parameters:
CPUS, 2, number of cores; only 2 is supported; other values are a compile-time error.
SNOOP_TIMEOUT, 16, cycles to wait for a snoop response before falling back to a RAM read.

Ports:
CLK  input  1  system clock, rising edge.
nRST  input  1  asynchronous active-low reset.
iREN/dREN/dWEN  input  [CPUS-1:0] each  per-core request strobes.
iaddr/daddr/dstore  input  [CPUS-1:0] word_t  per-core addresses and write data.
cctrans/ccwrite  input  [CPUS-1:0]  requester: miss transition / read-exclusive; snoopee: holds line in M.
ramload  input  word_t  RAM read data.
ramstate  input  ramstate_t  FREE/BUSY/ACCESS/ERROR.
iwait/dwait  output  [CPUS-1:0]  stall per core; low for exactly the completing cycle.
iload/dload  output  [CPUS-1:0] word_t  returned data, valid when the matching wait is low.
ccwait/ccinv  output  [CPUS-1:0]  snoop-stall / invalidate to snooped core.
ccsnoopaddr  output  [CPUS-1:0] word_t  snoop address to snooped core.
ramaddr/ramstore  output  word_t  RAM address/data.
ramREN/ramWEN  output  1  RAM strobes, never both high.

Behaviour:
- Reset state: all iwait/dwait = 1; ccwait/ccinv = 0; ramREN/ramWEN = 0; ramaddr/ramstore/ccsnoopaddr/iload/dload = 0; FSM = IDLE; rr_ptr = 0.
- FSM states: IDLE, IFETCH, DWB, DRD, SNOOP, C2C, INV.
- IDLE priority: dWEN (any core) > dREN > iREN. Within a class, the core is chosen by rr_ptr. Grant is registered, so the earliest transaction starts 1 cycle after the request.
- DWB: ramWEN = 1, ramaddr = daddr, ramstore = dstore of the granted core.
  - On ramstate == ACCESS: that core's dwait = 0 for one cycle, then IDLE.
- IFETCH: ramREN = 1 with iaddr.
  - On ACCESS: iwait = 0 and iload = ramload for one cycle, then IDLE.
- dREN with cctrans = 1 goes to SNOOP. The other core j gets ccwait[j] = 1 and ccsnoopaddr[j] = daddr. If the requester also has ccwrite = 1, ccinv[j] = 1.
  - If ccwrite[j] is seen within SNOOP_TIMEOUT cycles: go to C2C.
  - If cctrans[j] = 1 without ccwrite[j]: go to DRD.
  - On timeout: go to DRD.
- C2C: dload[req] = dstore[j]. In the same state, ramWEN = 1 with ramaddr = daddr[req] and ramstore = dstore[j]. On ACCESS: dwait[req] = 0 and dwait[j] = 0 (single cycle), then IDLE.
- DRD: ramREN = 1 with daddr. On ACCESS: dwait[req] = 0 and dload = ramload, then IDLE.
- dREN with cctrans = 0 is an upgrade (S to M) and goes to INV. INV asserts ccinv[j] and ccwait[j] for 2 cycles, then dwait[req] = 0 for one cycle with no RAM access, then IDLE.
- ccwait and ccinv drop in the cycle the FSM leaves SNOOP, C2C or INV.
- rr_ptr toggles only on a granted d-transaction that completes.
- ramstate == ERROR: treated as ACCESS, and the loaded data is passed through unchanged.
- ramstate == BUSY or FREE: hold all outputs.
- A request that is deasserted mid-transaction is ignored; the transaction completes. Requests must stay stable until their wait drops.
- nRST asserted mid-transaction: immediate return to IDLE with reset outputs. No partial RAM write is retried.
- Simultaneous dWEN from both cores: served in rr_ptr order, back to back, with 1 idle cycle between.

Optional Feature:
BUS_STATS_EN
- Defined: adds 32-bit saturating counters for snoop_hits (C2C entries), invalidations (INV entries plus ccinv-bearing SNOOPs) and ram_cycles (ramREN or ramWEN high). They are exposed as output ports stat_c2c, stat_inv and stat_ram and reset to 0.
- Undefined: the ports and counters are absent and the core behaviour is identical.

Test Plan:
1. Core0 iREN with iaddr = 0x100; RAM returns 0xDEADBEEF after 3 BUSY cycles -> iwait[0] low for exactly 1 cycle with iload[0] = 0xDEADBEEF; ramWEN never high.
2. Core0 and core1 both dWEN at cycle 0 with rr_ptr = 0 -> core0 written first, core1 second; ramstore matches each core's dstore; rr_ptr ends at 0.
3. Core0 dREN + cctrans + ccwrite at 0x200; core1 answers ccwrite = 1 with dstore = 0x1234 -> ccinv[1] = 1; dload[0] = 0x1234; RAM written 0x1234 at 0x200; dwait[0] and dwait[1] drop in the same cycle.
4. Core1 dREN + cctrans; core0 gives no response for 16 cycles -> timeout, RAM read; dload[1] = ramload; ccwait[0] cleared on exit from SNOOP.
5. Core0 upgrade (dREN, cctrans = 0) -> ccinv[1] high for 2 cycles; dwait[0] low on cycle 3; no ramREN or ramWEN.
6. nRST pulsed low during DWB with ramstate BUSY -> all outputs return to reset values asynchronously; the next request is granted normally.
